// File: rtl/fifo_rd_burst_drain_pkg.sv
// Shared types for the async-FIFO read-side burst drain: FSM encodings and default widths.
// Widths here must stay in step with the async FIFO instance the drain sits behind.
package asy_fifo_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 8;
    localparam int XFER_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;
endpackage

// File: rtl/fifo_rd_burst_drain_if.sv
// FIFO show-ahead read port plus the outgoing valid/ready word stream of the burst drain.
// master = the drain (pops the FIFO, drives the stream); slave = FIFO + stream consumer.
interface fifo_rd_burst_drain_if
    import asy_fifo_pkg::*;
    #(parameter int DATA_W = DEF_DATA_W);

    logic [DATA_W-1:0] fifo_r_data;
    logic              fifo_r_empty;
    logic              fifo_r_en;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        input  fifo_r_data, fifo_r_empty, m_ready,
        output fifo_r_en, m_data, m_valid, m_last
    );

    modport slave (
        output fifo_r_data, fifo_r_empty, m_ready,
        input  fifo_r_en, m_data, m_valid, m_last
    );
endinterface

// File: rtl/fifo_rd_burst_drain_out_buf.sv
// rd_out_buf2: 2-entry in-order output buffer; entry0 drives the stream outputs.
// Latency 1 cycle push to m_valid; backpressure via occ (caller must not push when occ==2 without a pop).
module rd_out_buf2
    import asy_fifo_pkg::*;
    #(parameter int DATA_W = DEF_DATA_W)
(
    input  logic              r_clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              m_ready,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last
);
    logic [DATA_W-1:0] d0, d1;
    logic              l0, l1;
    logic              pop;

    assign m_valid = (occ != 2'd0);
    assign m_data  = d0;
    assign m_last  = l0;
    assign pop     = m_valid & m_ready;

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= 2'd0;
            d0  <= '0;
            d1  <= '0;
            l0  <= 1'b0;
            l1  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        d0 <= push_data;
                        l0 <= push_last;
                    end else begin
                        d1 <= push_data;
                        l1 <= push_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    d0  <= d1;
                    l0  <= l1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: the new word lands behind whatever remains
                    if (occ == 2'd1) begin
                        d0 <= push_data;
                        l0 <= push_last;
                    end else begin
                        d0 <= d1;
                        l0 <= l1;
                        d1 <= push_data;
                        l1 <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fifo_rd_burst_drain.sv
// Pops burst_len words from a show-ahead FIFO and streams them out with m_last; optional FIFO_RD_XFER_CNT_EN adds xfer_cnt.
// Latency: FIFO head to m_valid 1 r_clk, one word/cycle sustained.
// Backpressure: pops stop when the 2-entry buffer is full; fifo_r_en has no combinational path from m_ready.
module fifo_rd_burst_drain
    import asy_fifo_pkg::*;
    #(
        parameter int DATA_W = DEF_DATA_W,
        parameter int LEN_W  = DEF_LEN_W
    )
(
    input  logic                     r_clk,
    input  logic                     rst_n,
    fifo_rd_burst_drain_if.master    sif,
    input  logic                     burst_start,
    input  logic [LEN_W-1:0]         burst_len,
    output logic                     busy,
    output logic                     done
`ifdef FIFO_RD_XFER_CNT_EN
    ,
    output logic [XFER_CNT_W-1:0]    xfer_cnt
`endif
);
    state_t            state, state_nxt;
    logic [LEN_W-1:0]  pops_left;
    logic              pop;
    logic [1:0]        occ;
    logic [DATA_W-1:0] buf_data;
    logic              buf_valid;
    logic              buf_last;
    logic              accept;
    logic              accept_last;

    assign pop         = (state == ST_RUN) & ~sif.fifo_r_empty &
                         (pops_left != '0) & (occ < 2'd2);
    assign accept      = buf_valid & sif.m_ready;
    assign accept_last = accept & buf_last;

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (burst_start && burst_len != '0)      state_nxt = ST_RUN;
            ST_RUN:   if (pop && pops_left == LEN_W'(1))       state_nxt = ST_FLUSH;
            ST_FLUSH: if (accept_last)                         state_nxt = ST_IDLE;
            default:                                           state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != ST_IDLE);
        sif.fifo_r_en = pop;
    end

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            pops_left <= '0;
            done      <= 1'b0;
        end else begin
            if (state == ST_IDLE && burst_start) pops_left <= burst_len;
            else if (pop)                        pops_left <= pops_left - LEN_W'(1);
            // Zero-length command completes without ever leaving IDLE
            done <= ((state == ST_IDLE) && burst_start && (burst_len == '0)) ||
                    ((state == ST_FLUSH) && accept_last);
        end
    end

    rd_out_buf2 #(.DATA_W(DATA_W)) u_out_buf (
        .r_clk     (r_clk),
        .rst_n     (rst_n),
        .push      (pop),
        .push_data (sif.fifo_r_data),
        .push_last (pops_left == LEN_W'(1)),
        .m_ready   (sif.m_ready),
        .occ       (occ),
        .m_data    (buf_data),
        .m_valid   (buf_valid),
        .m_last    (buf_last)
    );

    assign sif.m_data  = buf_data;
    assign sif.m_valid = buf_valid;
    assign sif.m_last  = buf_last;

`ifdef FIFO_RD_XFER_CNT_EN
    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n)      xfer_cnt <= '0;
        else if (accept) xfer_cnt <= xfer_cnt + XFER_CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_fifo_rd_burst_drain.sv
// Directed bench for fifo_rd_burst_drain: behavioural show-ahead FIFO, stream monitor, vector table
// for the single-burst cases and hand-written sequences for re-command, reset and the counter.
module tb_fifo_rd_burst_drain;
    logic        r_clk = 1'b0;
    logic        rst_n;
    logic        burst_start;
    logic [7:0]  burst_len;
    logic        busy;
    logic        done;
`ifdef FIFO_RD_XFER_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    fifo_rd_burst_drain_if #(.DATA_W(8)) ifc ();

    fifo_rd_burst_drain #(.DATA_W(8), .LEN_W(8)) dut (
        .r_clk       (r_clk),
        .rst_n       (rst_n),
        .sif         (ifc),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done)
`ifdef FIFO_RD_XFER_CNT_EN
        ,
        .xfer_cnt    (xfer_cnt)
`endif
    );

    always #5 r_clk = ~r_clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] fq[$];
    logic [7:0] rx_data[$];
    logic       rx_last[$];
    int  pops, done_cnt, done_cycle, viol_empty, viol_stable, cur_c;
    bit  busy_seen, en_s, prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    typedef struct {
        int         len;
        int         pre;
        int         late;
        int         late_at;
        int         stall;
        int         exp_done_c;
        int         exp_busy;
        int         exp_stall_pops;
        logic [7:0] base;
    } vec_t;
    vec_t vt[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        rx_data.delete();
        rx_last.delete();
        pops = 0; done_cnt = 0; done_cycle = -1;
        viol_empty = 0; viol_stable = 0; busy_seen = 0;
    endtask

    task automatic tick(input int c);
        @(posedge r_clk);
        #2;
        cur_c = c;
    endtask

    task automatic check_words(input string tag, input int n, input logic [7:0] base);
        int bad, lbad;
        bad = 0; lbad = 0;
        check({tag, "_words"}, rx_data.size(), n);
        for (int k = 0; k < rx_data.size(); k++) begin
            if (rx_data[k] !== base + 8'(k)) bad++;
            if (rx_last[k] !== (k == rx_data.size() - 1)) lbad++;
        end
        check({tag, "_order"}, bad, 0);
        check({tag, "_last"}, lbad, 0);
    endtask

    // Show-ahead FIFO model: pop after the edge where fifo_r_en was high, republish the head later
    initial begin
        ifc.fifo_r_empty = 1'b1;
        ifc.fifo_r_data  = 8'h00;
        forever begin
            @(posedge r_clk);
            #1;
            if (en_s && fq.size() > 0) fq.delete(0);
            #2;
            ifc.fifo_r_empty = (fq.size() == 0);
            ifc.fifo_r_data  = (fq.size() > 0) ? fq[0] : 8'h00;
        end
    end

    always @(negedge r_clk) begin
        if (rst_n) begin
            en_s = ifc.fifo_r_en;
            if (ifc.fifo_r_en) pops++;
            if (ifc.fifo_r_en && ifc.fifo_r_empty) viol_empty++;
            if (prev_stall && (!ifc.m_valid || ifc.m_data !== prev_data || ifc.m_last !== prev_last))
                viol_stable++;
            prev_stall = ifc.m_valid && !ifc.m_ready;
            prev_data  = ifc.m_data;
            prev_last  = ifc.m_last;
            if (ifc.m_valid && ifc.m_ready) begin
                rx_data.push_back(ifc.m_data);
                rx_last.push_back(ifc.m_last);
            end
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = cur_c;
            end
            if (busy) busy_seen = 1'b1;
        end else begin
            en_s       = 1'b0;
            prev_stall = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_pops;
        bit hit;
        vt[0] = '{len:4, pre:4, late:0, late_at:0,  stall:0, exp_done_c:6,  exp_busy:1, exp_stall_pops:0, base:8'hA0};
        vt[1] = '{len:6, pre:2, late:4, late_at:10, stall:0, exp_done_c:15, exp_busy:1, exp_stall_pops:0, base:8'h10};
        vt[2] = '{len:5, pre:5, late:0, late_at:0,  stall:8, exp_done_c:13, exp_busy:1, exp_stall_pops:2, base:8'h30};
        vt[3] = '{len:0, pre:0, late:0, late_at:0,  stall:0, exp_done_c:1,  exp_busy:0, exp_stall_pops:0, base:8'h00};

        rst_n = 1'b0; burst_start = 1'b0; burst_len = 8'd0; ifc.m_ready = 1'b0;
        cur_c = 0; stall_pops = 0;
        clear_stats();
        #1;
        check("rst_fifo_r_en", ifc.fifo_r_en, 0);
        check("rst_busy",      busy,          0);
        check("rst_done",      done,          0);
        check("rst_m_valid",   ifc.m_valid,   0);
        check("rst_m_last",    ifc.m_last,    0);
        check("rst_m_data",    ifc.m_data,    0);
`ifdef FIFO_RD_XFER_CNT_EN
        check("rst_xfer_cnt",  xfer_cnt,      0);
`endif
        repeat (3) @(posedge r_clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            tick(0);
            clear_stats();
            for (int k = 0; k < vt[i].pre; k++) fq.push_back(vt[i].base + 8'(k));
            ifc.m_ready = (vt[i].stall == 0);
            burst_start = 1'b1;
            burst_len   = 8'(vt[i].len);
            for (int c = 1; c <= 24; c++) begin
                tick(c);
                burst_start = 1'b0;
                if (vt[i].late > 0 && c == vt[i].late_at)
                    for (int k = 0; k < vt[i].late; k++)
                        fq.push_back(vt[i].base + 8'(vt[i].pre + k));
                if (vt[i].stall > 0 && c == vt[i].stall) begin
                    stall_pops  = pops;
                    ifc.m_ready = 1'b1;
                end
            end
            check_words($sformatf("v%0d", i), vt[i].len, vt[i].base);
            check($sformatf("v%0d_done_cnt", i),   done_cnt,   1);
            check($sformatf("v%0d_done_cycle", i), done_cycle, vt[i].exp_done_c);
            check($sformatf("v%0d_pops", i),       pops,       vt[i].len);
            check($sformatf("v%0d_pop_empty", i),  viol_empty, 0);
            check($sformatf("v%0d_hold", i),       viol_stable, 0);
            check($sformatf("v%0d_busy_seen", i),  busy_seen,  vt[i].exp_busy);
            check($sformatf("v%0d_fifo_left", i),  fq.size(),  0);
            check($sformatf("v%0d_busy_end", i),   busy,       0);
            if (vt[i].stall > 0)
                check($sformatf("v%0d_stall_pops", i), stall_pops, vt[i].exp_stall_pops);
        end

        // Re-command during RUN must not queue a second burst
        tick(0);
        clear_stats();
        for (int k = 0; k < 7; k++) fq.push_back(8'h50 + 8'(k));
        ifc.m_ready = 1'b1;
        burst_start = 1'b1;
        burst_len   = 8'd4;
        for (int c = 1; c <= 24; c++) begin
            tick(c);
            burst_start = (c == 2);
            if (c == 2) burst_len = 8'd3;
        end
        check_words("t5", 4, 8'h50);
        check("t5_done_cnt",   done_cnt,   1);
        check("t5_done_cycle", done_cycle, 6);
        check("t5_pops",       pops,       4);
        check("t5_fifo_left",  fq.size(),  3);
`ifdef FIFO_RD_XFER_CNT_EN
        check("xfer_cnt_total", xfer_cnt, 19);
`endif
        fq.delete();

        // Asynchronous reset in the middle of a burst
        tick(0);
        clear_stats();
        for (int k = 0; k < 8; k++) fq.push_back(8'h70 + 8'(k));
        burst_start = 1'b1;
        burst_len   = 8'd8;
        tick(1);
        burst_start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge r_clk);
            #1;
            if (rx_data.size() >= 2) hit = 1'b1;
        end
        check("t6_progress", hit, 1);
        check("t6_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_fifo_r_en", ifc.fifo_r_en, 0);
        check("t6_busy",      busy,          0);
        check("t6_done",      done,          0);
        check("t6_m_valid",   ifc.m_valid,   0);
        check("t6_m_last",    ifc.m_last,    0);
        check("t6_m_data",    ifc.m_data,    0);
        tick(0);
        fq.delete();
        repeat (2) @(posedge r_clk);
        #2;
        rst_n = 1'b1;
        tick(0);
        clear_stats();
        for (int k = 0; k < 3; k++) fq.push_back(8'h90 + 8'(k));
        burst_start = 1'b1;
        burst_len   = 8'd3;
        for (int c = 1; c <= 16; c++) begin
            tick(c);
            burst_start = 1'b0;
        end
        check_words("t6b", 3, 8'h90);
        check("t6b_done_cnt",   done_cnt,   1);
        check("t6b_done_cycle", done_cycle, 5);
        check("t6b_pops",       pops,       3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
